cmd_capture: RTL and testbench
==============================

CMD_CAPTURE -- requirements
Module: cmd_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the number of consecutive cycles a synchronized botao level must differ from the debounced level before it is accepted (legal range 1 to 2^20-1).
REQ-002 SHALL have one clock and a synchronous, active-high reset; no other clock domain exists inside the block.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, width 1: synchronous active-high reset.
REQ-005 SHALL have port botao, input, width 1: raw, asynchronous, bouncing push-button.
REQ-006 SHALL have port instrucao, input, width 4: command nibble from the switches.
REQ-007 SHALL have port dado, input, width 4: data nibble from the switches.
REQ-008 SHALL have port out_byte, output, width 8: FIFO head entry, {instrucao, dado}.
REQ-009 SHALL have port out_valid, output, width 1: FIFO non-empty.
REQ-010 SHALL have port out_ready, input, width 1: the downstream UART transmitter accepts out_byte.
REQ-011 SHALL have port count, output, width 3: FIFO fill level, 0 to 4.
REQ-012 SHALL have port overflow, output, width 1: sticky flag, set when a press is dropped.

Function
REQ-013 SHALL pass botao through a 2-flop synchronizer; botao_s is the second flop.
REQ-014 SHALL keep a debounced level deb and a counter of at least 20 bits; counter clears whenever botao_s equals deb.
REQ-015 SHALL, while botao_s differs from deb, increment the counter each cycle; in the cycle the counter equals DEBOUNCE_CYCLES-1, deb takes botao_s and the counter clears.
REQ-016 SHALL generate push in exactly the cycle deb changes 0->1; a 1->0 change generates nothing, and a press is counted only after the previous release was debounced.
REQ-017 SHALL, on push, write {instrucao, dado} as sampled on that same edge, instrucao in bits 7:4.
REQ-018 SHALL implement a 4-entry circular FIFO with 2-bit read/write pointers that wrap 3->0, plus count.
REQ-019 SHALL pop the head on every edge where out_valid and out_ready are both 1; out_ready with out_valid=0 has no effect.
REQ-020 SHALL drive out_valid = (count != 0) and out_byte = head entry when non-empty, 8'h00 when empty; out_byte SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, when full (count=4) with push and no pop, drop the push, leave the FIFO unchanged, and set overflow.
REQ-022 SHALL, when full with push and pop in the same cycle, perform both; count stays 4 and overflow is not set.
REQ-023 SHALL, when empty with push, write the entry; out_valid rises after that edge, so there is no same-cycle bypass.
REQ-024 SHALL have latency, with the FIFO empty and botao stable high: out_valid is 1 after the (DEBOUNCE_CYCLES+2)-th rising edge, counting the first edge that samples botao=1.
REQ-025 SHALL clear overflow only by rst.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, clear the synchronizer flops, deb, the debounce counter, the pointers, count, and overflow; out_valid=0, out_byte=8'h00, count=0, overflow=0 from the next cycle.
REQ-027 SHALL give rst priority over push and pop in the same cycle; the FIFO contents are discarded.
REQ-028 SHALL, if botao is held high through deassertion of rst mid-press, treat it as a new press: push after DEBOUNCE_CYCLES+2 edges.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 Single press: instrucao=4'hA, dado=4'h3, botao held high, out_ready=0 -> out_valid=1 after edge 6, out_byte=8'hA3, count=1; no second push while held.
REQ-030 Bounce: botao toggles every 2 cycles for 20 cycles, then stays high -> no push during toggling; exactly one push, 6 edges after the final rising transition.
REQ-031 Overflow: 5 clean presses with out_ready=0 (bytes 8'h11, 8'h22, 8'h33, 8'h44, 8'h55) -> count=4, overflow=1; then out_ready=1 -> bytes pop 11, 22, 33, 44 on consecutive edges; 55 never appears.
REQ-032 Full with simultaneous push and pop: count=4, out_ready=1 on the push edge -> count stays 4, overflow stays 0, new byte at the tail.
REQ-033 Wrap-around: 10 press/pop pairs with distinct bytes -> output order matches press order across pointer wrap; count returns to 0.
REQ-034 Reset mid-operation: count=3 and overflow=1, rst pulsed 1 cycle with botao high -> next cycle count=0, out_valid=0, out_byte=8'h00, overflow=0; then one push 6 edges after rst deasserts.

Source files
------------

// File: rtl/cmd_capture.sv
// Push-button command capture: synchronizes and debounces botao, stores
// {instrucao, dado} on each debounced press into a 4-entry FIFO for the UART.
module cmd_capture #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       botao,
  input  logic [3:0] instrucao,
  input  logic [3:0] dado,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] count,
  output logic       overflow
);

  localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_deb;
  logic [19:0] r_cnt;

  logic [7:0]  r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_overflow;

  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_wr;

  // The level change is accepted on the same edge that fires the push.
  assign w_accept = (r_sync2 != r_deb) && (r_cnt == DEB_LAST);
  assign w_push   = w_accept && r_sync2;
  assign w_pop    = out_valid && out_ready;
  assign w_full   = (r_count == 3'd4);
  assign w_wr     = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= 20'd0;
    end else begin
      r_sync1 <= botao;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= 20'd0;
      end else if (w_accept) begin
        r_deb <= r_sync2;
        r_cnt <= 20'd0;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr && !rst) begin
      r_mem[r_wr_ptr] <= {instrucao, dado};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid = (r_count != 3'd0);
  assign out_byte  = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_cmd_capture.sv
// Directed bench for cmd_capture with a byte scoreboard checked on every pop.
module tb_cmd_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       botao = 1'b0;
  logic [3:0] instrucao = 4'h0;
  logic [3:0] dado = 4'h0;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb_q [$];

  always #5 clk = ~clk;

  cmd_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .botao(botao), .instrucao(instrucao), .dado(dado),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-12s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle; a pop about to happen is checked against the scoreboard.
  task automatic cyc();
    logic [7:0] exp;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_pop observed=%h expected=none", out_byte);
      end else begin
        exp = sb_q.pop_front();
        chk("pop_byte", out_byte, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press_hold(input logic [7:0] b);
    {instrucao, dado} = b;
    botao = 1'b1;
    cycles(6);
  endtask

  task automatic release_btn();
    botao = 1'b0;
    cycles(8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    @(negedge clk);
    cycles(2);
    rst = 1'b0;
    sb_q.delete();
    chk("rst_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_byte", out_byte, 8'h00);
    chk("rst_count", {5'd0, count}, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);

    // Single press with latency check
    instrucao = 4'hA; dado = 4'h3; botao = 1'b1;
    cycles(5);
    chk("lat_edge5", {7'd0, out_valid}, 8'h00);
    cyc();
    chk("lat_edge6", {7'd0, out_valid}, 8'h01);
    chk("single_byte", out_byte, 8'hA3);
    chk("single_cnt", {5'd0, count}, 8'h01);
    sb_q.push_back(8'hA3);
    cycles(12);
    chk("held_cnt", {5'd0, count}, 8'h01);
    chk("held_byte", out_byte, 8'hA3);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    release_btn();
    chk("rel_cnt", {5'd0, count}, 8'h00);

    // Bounce: toggling every 2 cycles must never be accepted
    instrucao = 4'h5; dado = 4'hC;
    for (int i = 0; i < 20; i++) begin
      botao = ((i / 2) % 2 == 0);
      cyc();
    end
    chk("bounce_cnt", {5'd0, count}, 8'h00);
    botao = 1'b1;
    cycles(5);
    chk("bnc_edge5", {5'd0, count}, 8'h00);
    cyc();
    chk("bnc_edge6", {5'd0, count}, 8'h01);
    sb_q.push_back(8'h5C);
    cycles(6);
    chk("bnc_once", {5'd0, count}, 8'h01);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    release_btn();

    // Overflow: fifth press dropped
    for (int k = 1; k <= 5; k++) begin
      press_hold(8'(k * 8'h11));
      if (k <= 4) sb_q.push_back(8'(k * 8'h11));
      release_btn();
    end
    chk("ovf_cnt", {5'd0, count}, 8'h04);
    chk("ovf_flag", {7'd0, overflow}, 8'h01);
    chk("ovf_head", out_byte, 8'h11);
    out_ready = 1'b1;
    cycles(4);
    chk("ovf_drain", {7'd0, out_valid}, 8'h00);
    chk("ovf_sticky", {7'd0, overflow}, 8'h01);
    cycles(2);
    out_ready = 1'b0;

    // Full with simultaneous push and pop
    do_reset();
    chk("rst2_ovf", {7'd0, overflow}, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      press_hold(8'(8'h60 + k));
      sb_q.push_back(8'(8'h60 + k));
      release_btn();
    end
    chk("full_cnt", {5'd0, count}, 8'h04);
    {instrucao, dado} = 8'h65;
    botao = 1'b1;
    cycles(5);
    sb_q.push_back(8'h65);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("pp_cnt", {5'd0, count}, 8'h04);
    chk("pp_ovf", {7'd0, overflow}, 8'h00);
    chk("pp_head", out_byte, 8'h62);
    release_btn();
    out_ready = 1'b1;
    cycles(4);
    out_ready = 1'b0;
    chk("pp_empty", {5'd0, count}, 8'h00);

    // Wrap-around: press/pop pairs
    for (int k = 0; k < 10; k++) begin
      press_hold({4'(k), 4'(~k)});
      sb_q.push_back({4'(k), 4'(~k)});
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      release_btn();
    end
    chk("wrap_cnt", {5'd0, count}, 8'h00);
    chk("wrap_sb", 8'(sb_q.size()), 8'h00);

    // Reset mid-operation with button held high
    for (int k = 1; k <= 5; k++) begin
      press_hold(8'(8'h90 + k));
      if (k <= 4) sb_q.push_back(8'(8'h90 + k));
      release_btn();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("mid_cnt", {5'd0, count}, 8'h03);
    chk("mid_ovf", {7'd0, overflow}, 8'h01);
    {instrucao, dado} = 8'h9E;
    botao = 1'b1;
    do_reset();
    chk("mr_cnt", {5'd0, count}, 8'h00);
    chk("mr_valid", {7'd0, out_valid}, 8'h00);
    chk("mr_byte", out_byte, 8'h00);
    chk("mr_ovf", {7'd0, overflow}, 8'h00);
    cycles(5);
    chk("mr_edge5", {5'd0, count}, 8'h00);
    cyc();
    chk("mr_edge6", {5'd0, count}, 8'h01);
    chk("mr_pbyte", out_byte, 8'h9E);
    sb_q.push_back(8'h9E);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    release_btn();
    chk("end_cnt", {5'd0, count}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
